// File: rtl/button_pkg.sv
// Shared definitions for the button UI: phase codes (also used by the UI FSM),
// result status codes and the default WAIT timeout.
package button_pkg;

  typedef enum logic [3:0] {
    PH_POC = 4'b0000,
    PH_WP  = 4'b0001,
    PH_WC  = 4'b0010,
    PH_PD  = 4'b0101,
    PH_CP  = 4'b0110
  } phase_e;

  typedef enum logic [2:0] {
    ST_NONE     = 3'd0,
    ST_ACCEPTED = 3'd1,
    ST_REJECTED = 3'd2,
    ST_TIMEOUT  = 3'd3,
    ST_INVALID  = 3'd4,
    ST_DROPPED  = 3'd5
  } status_e;

  typedef enum logic [1:0] {
    IS_IDLE  = 2'd0,
    IS_ISSUE = 2'd1,
    IS_WAIT  = 2'd2
  } issue_e;

  localparam int TIMEOUT_CYC_DEF = 255;

  localparam logic [3:0] BTN_OWN     = 4'b1000;
  localparam logic [3:0] BTN_CAPTIVE = 4'b0100;

endpackage

// File: rtl/move_cmd_gen_if.sv
// Command handshake between the move generator (master) and the board logic (slave).
interface move_cmd_gen_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_kind;
  logic [1:0] cmd_src;
  logic [1:0] cmd_arg;
  logic       cmd_done;
  logic       cmd_ok;

  modport master (
    output cmd_valid, cmd_kind, cmd_src, cmd_arg,
    input  cmd_ready, cmd_done, cmd_ok
  );

  modport slave (
    input  cmd_valid, cmd_kind, cmd_src, cmd_arg,
    output cmd_ready, cmd_done, cmd_ok
  );

endinterface

// File: rtl/btn_index_enc.sv
// One-hot button pulse to 2-bit index; bit3 is button 0. Multi-hot or zero is not valid.
module btn_index_enc (
  input  logic [3:0] i_control,
  output logic [1:0] o_idx,
  output logic       o_valid
);

  always_comb begin
    o_idx   = 2'd0;
    o_valid = 1'b0;
    case (i_control)
      4'b1000: begin o_idx = 2'd0; o_valid = 1'b1; end
      4'b0100: begin o_idx = 2'd1; o_valid = 1'b1; end
      4'b0010: begin o_idx = 2'd2; o_valid = 1'b1; end
      4'b0001: begin o_idx = 2'd3; o_valid = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/move_cmd_gen.sv
// Tracks the three-press selection, issues the resulting move/drop command over a
// valid/ready handshake and waits for the board's completion or a timeout.
//
// issue state | meaning
// IS_IDLE     | no command outstanding; a valid completed selection is issued
// IS_ISSUE    | cmd_valid high, fields frozen until cmd_ready
// IS_WAIT     | accepted, waiting for cmd_done or TIMEOUT_CYC cycles
module move_cmd_gen
  import button_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     i_control,
  input  logic [3:0]     i_ui_state,
  move_cmd_gen_if.master cmd,
  output logic           o_busy,
  output logic [2:0]     o_status,
  output logic           o_sync_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  phase_e           r_phase;
  phase_e           r_phase_d;
  logic             r_sync_err;
  logic             r_sel_kind;
  logic [1:0]       r_sel_src;
  logic             r_sel_good;

  issue_e           r_state;
  logic             r_valid;
  logic             r_kind;
  logic [1:0]       r_src;
  logic [1:0]       r_arg;
  status_e          r_status;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_idx;
  logic             w_idx_ok;
  logic             w_press;
  logic             w_complete;
  logic             w_sel_good;

  btn_index_enc u_enc (
    .i_control (i_control),
    .o_idx     (w_idx),
    .o_valid   (w_idx_ok)
  );

  assign w_press    = |i_control;
  assign w_complete = ((r_phase == PH_PD) || (r_phase == PH_CP)) && w_press;
  assign w_sel_good = r_sel_good & w_idx_ok;

  // Phase tracker mirrors the UI FSM so the selection can be captured locally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= PH_POC;
      r_phase_d  <= PH_POC;
      r_sync_err <= 1'b0;
      r_sel_kind <= 1'b0;
      r_sel_src  <= 2'd0;
      r_sel_good <= 1'b0;
    end else begin
      r_phase_d <= r_phase;
      if (r_phase_d != i_ui_state)
        r_sync_err <= 1'b1;
      case (r_phase)
        PH_POC: begin
          if (i_control == BTN_OWN)
            r_phase <= PH_WP;
          else if (i_control == BTN_CAPTIVE)
            r_phase <= PH_WC;
        end
        PH_WP, PH_WC: begin
          if (w_press) begin
            r_phase    <= (r_phase == PH_WP) ? PH_PD : PH_CP;
            r_sel_kind <= (r_phase == PH_WC);
            r_sel_src  <= w_idx;
            r_sel_good <= w_idx_ok;
          end
        end
        PH_PD, PH_CP: begin
          if (w_press)
            r_phase <= PH_POC;
        end
        default: r_phase <= PH_POC;
      endcase
    end
  end

  // Completion handling comes after the state case so a drop/invalid report on
  // the same edge as a WAIT exit is the one that is left in status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IS_IDLE;
      r_valid  <= 1'b0;
      r_kind   <= 1'b0;
      r_src    <= 2'd0;
      r_arg    <= 2'd0;
      r_status <= ST_NONE;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IS_IDLE: ;
        IS_ISSUE: begin
          if (r_valid && cmd.cmd_ready) begin
            r_state <= IS_WAIT;
            r_valid <= 1'b0;
            r_cnt   <= '0;
          end
        end
        IS_WAIT: begin
          if (cmd.cmd_done) begin
            r_state  <= IS_IDLE;
            r_status <= cmd.cmd_ok ? ST_ACCEPTED : ST_REJECTED;
          end else if (r_cnt == CNT_LAST) begin
            r_state  <= IS_IDLE;
            r_status <= ST_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IS_IDLE;
      endcase

      if (w_complete) begin
        if (!w_sel_good) begin
          r_status <= ST_INVALID;
        end else if (r_state != IS_IDLE) begin
          r_status <= ST_DROPPED;
        end else begin
          r_state <= IS_ISSUE;
          r_valid <= 1'b1;
          r_kind  <= r_sel_kind;
          r_src   <= r_sel_src;
          r_arg   <= w_idx;
        end
      end
    end
  end

  assign cmd.cmd_valid = r_valid;
  assign cmd.cmd_kind  = r_kind;
  assign cmd.cmd_src   = r_src;
  assign cmd.cmd_arg   = r_arg;

  assign o_busy     = (r_state != IS_IDLE);
  assign o_status   = r_status;
  assign o_sync_err = r_sync_err;

endmodule

// File: tb/tb_move_cmd_gen.sv
// Directed and random stimulus for move_cmd_gen, checked every cycle against a
// selection/transaction-level reference model.
module tb_move_cmd_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] control;
  logic [3:0] ui_state;
  logic       busy;
  logic [2:0] status;
  logic       sync_err;

  move_cmd_gen_if bus ();

  move_cmd_gen #(.TIMEOUT_CYC(255)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_control  (control),
    .i_ui_state (ui_state),
    .cmd        (bus),
    .o_busy     (busy),
    .o_status   (status),
    .o_sync_err (sync_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the presses of the selection in progress, the command
  // stage (0 none, 1 offered, 2 outstanding) and the reported results.
  logic [3:0] q[$];
  int         m_st;
  logic       m_kind;
  logic [1:0] m_src;
  logic [1:0] m_arg;
  logic [2:0] m_status;
  logic       m_sync;
  logic [3:0] m_phase_prev;
  int         cyc;
  int         wait_start;
  bit         ui_force;
  logic [3:0] ui_force_val;

  function automatic logic [3:0] phase_of();
    if (q.size() == 0) return 4'b0000;
    if (q.size() == 1) return (q[0] == 4'b1000) ? 4'b0001 : 4'b0010;
    return (q[0] == 4'b1000) ? 4'b0101 : 4'b0110;
  endfunction

  function automatic bit onehot(logic [3:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic logic [1:0] idx_of(logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[3-i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_st = 0; m_kind = 1'b0; m_src = 2'd0; m_arg = 2'd0;
    m_status = 3'd0; m_sync = 1'b0; m_phase_prev = 4'b0000;
    cyc = 0; wait_start = 0;
  endtask

  task automatic model_edge();
    logic [3:0] ph;
    bit old_busy;
    bit complete;
    cyc++;
    ph = phase_of();
    if (ui_state !== m_phase_prev) m_sync = 1'b1;
    old_busy = (m_st != 0);
    complete = (q.size() == 2) && (control != 4'b0000);
    case (m_st)
      1: if (bus.cmd_ready) begin m_st = 2; wait_start = cyc; end
      2: begin
        if (bus.cmd_done) begin
          m_st = 0; m_status = bus.cmd_ok ? 3'd1 : 3'd2;
        end else if (cyc - wait_start == 255) begin
          m_st = 0; m_status = 3'd3;
        end
      end
      default: ;
    endcase
    if (complete) begin
      if (!(onehot(q[1]) && onehot(control))) m_status = 3'd4;
      else if (old_busy) m_status = 3'd5;
      else begin
        m_st = 1; m_kind = (q[0] == 4'b0100);
        m_src = idx_of(q[1]); m_arg = idx_of(control);
      end
    end
    if (q.size() == 0) begin
      if (control == 4'b1000 || control == 4'b0100) q.push_back(control);
    end else if (control != 4'b0000) begin
      q.push_back(control);
      if (q.size() == 3) q.delete();
    end
    m_phase_prev = ph;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("cmd_valid", 8'(bus.cmd_valid), 8'(m_st == 1));
    chk("busy",      8'(busy),          8'(m_st != 0));
    chk("status",    8'(status),        8'(m_status));
    chk("sync_err",  8'(sync_err),      8'(m_sync));
    chk("cmd_kind",  8'(bus.cmd_kind),  8'(m_kind));
    chk("cmd_src",   8'(bus.cmd_src),   8'(m_src));
    chk("cmd_arg",   8'(bus.cmd_arg),   8'(m_arg));
  endtask

  task automatic cycle(input logic [3:0] c, input logic rdy, input logic dn, input logic ok);
    @(negedge clk);
    control = c; bus.cmd_ready = rdy; bus.cmd_done = dn; bus.cmd_ok = ok;
    ui_state = ui_force ? ui_force_val : m_phase_prev;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    control = 4'b0000; bus.cmd_ready = 1'b0; bus.cmd_done = 1'b0; bus.cmd_ok = 1'b0;
    ui_state = 4'b0000;
    #1;
    model_reset();
    check_all();
    chk("rst_valid",  8'(bus.cmd_valid), 8'd0);
    chk("rst_busy",   8'(busy),          8'd0);
    chk("rst_status", 8'(status),        8'd0);
    chk("rst_sync",   8'(sync_err),      8'd0);
    chk("rst_fields", 8'({bus.cmd_kind, bus.cmd_src, bus.cmd_arg}), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ui_state = m_phase_prev;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    control = 4'b0000; ui_state = 4'b0000;
    bus.cmd_ready = 1'b0; bus.cmd_done = 1'b0; bus.cmd_ok = 1'b0;
    ui_force = 1'b0; ui_force_val = 4'b0000;
    model_reset();
    do_reset();

    // own-piece move, immediate ready, accepted
    cycle(4'b1000, 1'b1, 1'b0, 1'b0);
    cycle(4'b0100, 1'b1, 1'b0, 1'b0);
    cycle(4'b0010, 1'b1, 1'b0, 1'b0);
    chk("move_fields", 8'({bus.cmd_valid, bus.cmd_kind, bus.cmd_src, bus.cmd_arg}), 8'b1_0_01_10);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b1, 1'b1);
    chk("move_status", 8'(status), 8'd1);

    // captive drop with ready held low, then rejected
    cycle(4'b0100, 1'b0, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b1, 1'b1);
    cycle(4'b1000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0000, 1'b0, 1'b1, 1'b1);
      chk("drop_hold", 8'({bus.cmd_valid, bus.cmd_kind, bus.cmd_src, bus.cmd_arg}), 8'b1_1_11_00);
    end
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("drop_accept", 8'(bus.cmd_valid), 8'd0);
    cycle(4'b0000, 1'b0, 1'b1, 1'b0);
    chk("drop_status", 8'(status), 8'd2);

    // multi-hot press invalidates the selection
    cycle(4'b1000, 1'b1, 1'b0, 1'b0);
    cycle(4'b1100, 1'b1, 1'b0, 1'b0);
    cycle(4'b0010, 1'b1, 1'b0, 1'b0);
    chk("inv_status", 8'({bus.cmd_valid, status}), 8'({1'b0, 3'd4}));

    // accepted command with no completion times out
    cycle(4'b1000, 1'b1, 1'b0, 1'b0);
    cycle(4'b0001, 1'b1, 1'b0, 1'b0);
    cycle(4'b0001, 1'b1, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 254; i++) cycle(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("to_busy_last", 8'(busy), 8'd1);
    cycle(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("to_status", 8'({busy, status}), 8'({1'b0, 3'd3}));

    // second selection while waiting is dropped
    cycle(4'b1000, 1'b1, 1'b0, 1'b0);
    cycle(4'b0100, 1'b1, 1'b0, 1'b0);
    cycle(4'b0010, 1'b1, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);
    cycle(4'b0100, 1'b0, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0, 1'b0);
    cycle(4'b1000, 1'b0, 1'b0, 1'b0);
    chk("busy_drop", 8'({status, bus.cmd_kind, bus.cmd_src, bus.cmd_arg}), 8'({3'd5, 1'b0, 2'd1, 2'd2}));
    cycle(4'b0000, 1'b0, 1'b1, 1'b1);

    // ui_state disagrees while in PD
    cycle(4'b1000, 1'b0, 1'b0, 1'b0);
    cycle(4'b0100, 1'b0, 1'b0, 1'b0);
    ui_force = 1'b1; ui_force_val = 4'b0000;
    cycle(4'b0000, 1'b0, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("sync_set", 8'(sync_err), 8'd1);

    // reset while the command is offered
    cycle(4'b0010, 1'b0, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_valid", 8'(bus.cmd_valid), 8'd1);
    ui_force = 1'b0;
    do_reset();

    // random presses and board responses
    for (int i = 0; i < 800; i++) begin
      int r;
      logic [3:0] c;
      r = int'($urandom_range(0, 9));
      if (r < 5) c = 4'b0000;
      else if (r < 9) c = 4'b1000 >> $urandom_range(0, 3);
      else c = 4'($urandom_range(1, 15));
      cycle(c, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
